// File: rtl/game_round_scheduler.sv
// game_round_scheduler
//   Sequences the rounds of the reaction game. Each round waits a randomised
//   delay, then opens a timed window on one target LED and records a hit or
//   a miss. The window shortens as the hit count rises. After ROUNDS rounds
//   the game ends and waits for another start.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   start         raw start/abort button level (rising edge used)
//   ms_tick       one-cycle pulse every millisecond
//   random_value  random LED index, may be >= LED_NUM
//   random_delay  random delay component in ms
//   hit           one-cycle pulse: player matched the target LED
//   led_index     target LED of the current round, always < LED_NUM
//   led_valid     high only while the window is open
//   window_ms     window length applied to the current/next round
//   round_count   completed rounds this game
//   hit_count     hits this game
//   level         difficulty level
//   round_done    one-cycle pulse when a round completes
//   busy          high while a game is in progress
//   game_over     high once all rounds are played
module game_round_scheduler #(
    parameter int MAX_MS         = 2047,
    parameter int LED_NUM        = 18,
    parameter int ROUNDS         = 10,
    parameter int MIN_DELAY_MS   = 500,
    parameter int BASE_WINDOW_MS = 1000,
    parameter int WINDOW_STEP_MS = 125,
    parameter int MIN_WINDOW_MS  = 250,
    localparam int CW            = $clog2(MAX_MS),
    localparam int IW            = $clog2(LED_NUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ms_tick,
    input  logic [IW-1:0] random_value,
    input  logic [9:0]    random_delay,
    input  logic          hit,
    output logic [IW-1:0] led_index,
    output logic          led_valid,
    output logic [CW-1:0] window_ms,
    output logic [3:0]    round_count,
    output logic [3:0]    hit_count,
    output logic [2:0]    level,
    output logic          round_done,
    output logic          busy,
    output logic          game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_WINDOW,
        S_SCORE,
        S_MISS,
        S_DONE
    } state_t;

    state_t        state;
    logic          start_q;
    logic [CW-1:0] delay_cnt;
    logic [CW-1:0] win_cnt;

    logic          start_edge;
    logic [3:0]    rc_inc;
    logic [3:0]    hc_inc;
    logic [2:0]    lvl_inc;

    // Window length for a level, computed signed so a large level clamps to
    // the floor instead of wrapping.
    function automatic logic [CW-1:0] window_for(input logic [2:0] lv);
        int w;
        w = BASE_WINDOW_MS - int'(lv) * WINDOW_STEP_MS;
        if (w < MIN_WINDOW_MS)
            w = MIN_WINDOW_MS;
        return CW'(w);
    endfunction

    assign start_edge = start & ~start_q;
    assign rc_inc     = round_count + 4'd1;
    assign hc_inc     = (hit_count == 4'hF) ? 4'hF : hit_count + 4'd1;
    // hit_count is 4 bits, so hit_count>>1 never exceeds 7.
    assign lvl_inc    = hc_inc[3:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            delay_cnt   <= '0;
            win_cnt     <= '0;
            led_index   <= '0;
            led_valid   <= 1'b0;
            window_ms   <= CW'(BASE_WINDOW_MS);
            round_count <= '0;
            hit_count   <= '0;
            level       <= '0;
            round_done  <= 1'b0;
            busy        <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            start_q    <= start;
            round_done <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        round_count <= '0;
                        hit_count   <= '0;
                        level       <= '0;
                        window_ms   <= CW'(BASE_WINDOW_MS);
                        busy        <= 1'b1;
                        game_over   <= 1'b0;
                        state       <= S_ARM;
                    end
                end

                S_ARM: begin
                    delay_cnt <= CW'(MIN_DELAY_MS) + CW'(random_delay);
                    // A single subtraction suffices: random_value < 2*LED_NUM.
                    led_index <= (int'(random_value) >= LED_NUM)
                                 ? random_value - IW'(LED_NUM) : random_value;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    if (start_edge) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (ms_tick) begin
                        if (delay_cnt == CW'(1)) begin
                            win_cnt   <= window_ms;
                            led_valid <= 1'b1;
                            state     <= S_WINDOW;
                        end else begin
                            delay_cnt <= delay_cnt - CW'(1);
                        end
                    end
                end

                S_WINDOW: begin
                    if (start_edge) begin
                        led_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (hit) begin
                        // Checked before the tick: a hit on the expiring tick scores.
                        led_valid <= 1'b0;
                        state     <= S_SCORE;
                    end else if (ms_tick) begin
                        if (win_cnt == CW'(1)) begin
                            led_valid <= 1'b0;
                            state     <= S_MISS;
                        end else begin
                            win_cnt <= win_cnt - CW'(1);
                        end
                    end
                end

                S_SCORE, S_MISS: begin
                    if (state == S_SCORE) begin
                        hit_count <= hc_inc;
                        level     <= lvl_inc;
                        window_ms <= window_for(lvl_inc);
                    end
                    round_count <= rc_inc;
                    round_done  <= 1'b1;
                    if (rc_inc == 4'(ROUNDS)) begin
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_ARM;
                    end
                end

                default: begin
                    led_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_scheduler.sv
module tb_game_round_scheduler;

    localparam int IW = 5;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ms_tick;
    logic [IW-1:0] random_value;
    logic [9:0]    random_delay;
    logic          hit;
    logic [IW-1:0] led_index;
    logic          led_valid;
    logic [CW-1:0] window_ms;
    logic [3:0]    round_count;
    logic [3:0]    hit_count;
    logic [2:0]    level;
    logic          round_done;
    logic          busy;
    logic          game_over;

    int n_tests = 0;
    int n_fail  = 0;

    game_round_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ms_tick      (ms_tick),
        .random_value (random_value),
        .random_delay (random_delay),
        .hit          (hit),
        .led_index    (led_index),
        .led_valid    (led_valid),
        .window_ms    (window_ms),
        .round_count  (round_count),
        .hit_count    (hit_count),
        .level        (level),
        .round_done   (round_done),
        .busy         (busy),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and outputs are handled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One ms_tick pulse followed by an idle cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ms_tick = 1'b1;
            cyc();
            ms_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".led_index"},   led_index,   0);
        check({tag, ".led_valid"},   led_valid,   0);
        check({tag, ".window_ms"},   window_ms,   1000);
        check({tag, ".round_count"}, round_count, 0);
        check({tag, ".hit_count"},   hit_count,   0);
        check({tag, ".level"},       level,       0);
        check({tag, ".round_done"},  round_done,  0);
        check({tag, ".busy"},        busy,        0);
        check({tag, ".game_over"},   game_over,   0);
    endtask

    int exp_win [10] = '{1000, 1000, 875, 875, 750, 750, 625, 625, 500, 500};

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        ms_tick      = 1'b0;
        hit          = 1'b0;
        random_value = 5'd20;
        random_delay = 10'd0;
        cyc();
        cyc();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Game 1: delay, index folding, miss, abort.
        pulse_start();
        check("start.busy", busy, 1);
        cyc();
        check("fold20.led_index", led_index, 2);
        ticks(499);
        check("wait499.led_valid", led_valid, 0);
        ticks(1);
        check("wait500.led_valid", led_valid, 1);
        ticks(999);
        check("win999.led_valid", led_valid, 1);
        ticks(1);
        check("miss.led_valid", led_valid, 0);
        check("miss.round_done", round_done, 1);
        check("miss.round_count", round_count, 1);
        check("miss.hit_count", hit_count, 0);
        random_value = 5'd17;
        cyc();
        check("fold17.led_index", led_index, 17);
        check("miss.round_done_low", round_done, 0);
        ticks(500);
        check("win2.led_valid", led_valid, 1);
        pulse_start();
        check("abort.led_valid", led_valid, 0);
        check("abort.busy", busy, 0);
        check("abort.round_count", round_count, 1);
        check("abort.round_done", round_done, 0);
        cyc();

        // Game 2: hit every round, window shrinks with level.
        pulse_start();
        check("g2.round_count_clr", round_count, 0);
        for (int r = 0; r < 10; r++) begin
            cyc();
            check($sformatf("g2.r%0d.window_ms", r), window_ms, exp_win[r]);
            ticks(500);
            check($sformatf("g2.r%0d.led_valid", r), led_valid, 1);
            ticks(3);
            hit = 1'b1;
            cyc();
            hit = 1'b0;
            check($sformatf("g2.r%0d.hit_lat", r), hit_count, r);
            cyc();
            check($sformatf("g2.r%0d.hit_count", r), hit_count, r + 1);
            check($sformatf("g2.r%0d.round_count", r), round_count, r + 1);
            check($sformatf("g2.r%0d.round_done", r), round_done, 1);
        end
        check("g2.game_over", game_over, 1);
        check("g2.busy", busy, 0);
        check("g2.level", level, 5);
        check("g2.window_ms", window_ms, 375);
        check("g2.led_index_held", led_index, 17);
        cyc();
        check("g2.hit_count_held", hit_count, 10);

        // Game 3: hit on the expiring tick, hit ignored in WAIT, reset mid-WAIT.
        pulse_start();
        check("g3.game_over", game_over, 0);
        check("g3.window_ms", window_ms, 1000);
        check("g3.hit_count_clr", hit_count, 0);
        cyc();
        ticks(500);
        ticks(999);
        check("g3.led_valid", led_valid, 1);
        hit     = 1'b1;
        ms_tick = 1'b1;
        cyc();
        hit     = 1'b0;
        ms_tick = 1'b0;
        cyc();
        check("coincide.hit_count", hit_count, 1);
        check("coincide.round_done", round_done, 1);
        cyc();
        ticks(10);
        hit = 1'b1;
        cyc();
        hit = 1'b0;
        cyc();
        check("waithit.hit_count", hit_count, 1);
        check("waithit.led_valid", led_valid, 0);
        check("waithit.busy", busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_reset_outputs("midreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
